mpu_host: RTL and testbench
===========================

# mpu_host

MPU-401 host-side initiator: drives the two-register MPU-401 port (command/status at address 1, data at address 0) from inside the FPGA instead of from the CPU. After reset it puts the MPU into UART mode and then shuttles MIDI bytes between the port and two byte streams. It sits between the on-chip MIDI synth/sequencer logic and the `mpu` UART block, acting as the bus master of that block's register interface.

## Interface
- `POLL_GAP`, 3: idle cycles between consecutive status polls when nothing is pending.
- `ACK_TIMEOUT`, 65535: cycles allowed for an 0xFE acknowledge after a command write.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mpu_cs`, `mpu_address`, `mpu_read`, `mpu_write`  out  1 each  one-cycle bus strobes to the MPU port (address 1 = command/status, 0 = data).
- `mpu_writedata`  out  8  write data, valid with `mpu_write`.
- `mpu_readdata`  in  8  slave read data, registered by the slave: valid the cycle after the `mpu_read` strobe.
- `tx_data`  in  8  MIDI byte to send.
- `tx_valid`  in  1  `tx_data` valid; hold until accepted.
- `tx_ready`  out  1  byte accepted when `tx_valid & tx_ready`.
- `rx_data`  out  8  received MIDI byte; held until the next one.
- `rx_valid`  out  1  one-cycle pulse per received byte; no backpressure.
- `reinit`  in  1  pulse: rerun the init sequence.
- `online`  out  1  UART mode established.
- `error`  out  1  init failed (ack timeout); sticky until `reinit` or reset.

## Operation
- Status byte: bit7 = 0 means data available; bit6 = 1 means output full. Other bits are ignored.
- Status poll = one read strobe at address 1, then an EVAL cycle that samples `mpu_readdata`.
- Init FSM:
  - `C_POLL`: poll status until bit6 = 0.
  - `C_WR`: write the command (0xFF first, 0x3F second) to address 1.
  - `A_POLL`: poll status until bit7 = 0.
  - `A_RD`: read address 0 and sample the byte.
    - 0xFE means ACK: after 0xFF go to `C_POLL` with 0x3F; after 0x3F go to `ONLINE`.
    - Any other byte is discarded and the FSM returns to `A_POLL`.
  - The timeout counter is cleared at `C_WR` and runs through `A_POLL`/`A_RD`. It is not cleared by discarded bytes.
  - Reset-ack timeout:
    - On the first timeout of the 0xFF ack, resend 0xFF once. A port already in UART mode does not ack the first reset.
    - A second timeout, or a timeout on the 0x3F ack, goes to `ERROR`: `error` = 1, `online` = 0, no bus activity.
- `ONLINE` loop: `STATUS` strobe, then `EVAL`. Actions, in priority order:
  - bit7 = 0: `RX_RD` (read address 0, then pulse `rx_valid` with the byte).
  - Else `tx_valid` & bit6 = 0: `TX_WR` (write `tx_data` to address 0, `tx_ready` = 1 in that cycle only).
  - Else `GAP` for `POLL_GAP` cycles, then `STATUS`.
  - After `RX_RD`/`TX_WR`, go directly to `STATUS`.
- `reinit` is sampled only in `EVAL`, `GAP` or `ERROR`; it clears `online`/`error` and enters `C_POLL` with 0xFF. Bus transactions are never cut short.
- 0xFE read in `ONLINE` is an ordinary MIDI byte and is forwarded.

## Timing
- Reset values:
  - All strobes 0; `mpu_writedata` = 0x00.
  - `rx_data` = 0x00; `rx_valid`, `tx_ready`, `online`, `error` = 0.
  - State `C_POLL` (command 0xFF), counters 0.
- Reset is asynchronous on assertion. The FSM runs from the first edge after deassertion.
- At most one strobe per cycle; never two strobes on consecutive cycles except `TX_WR` → `STATUS`.
- TX latency: `tx_valid` rising in `GAP` → accept ≤ POLL_GAP+3 cycles. From `STATUS` it is exactly 2 cycles.
- RX: `rx_valid` fires 2 cycles after the `RX_RD` strobe.
- Timeout counter: width `$clog2(ACK_TIMEOUT+1)`, saturating. Timeout fires when it equals `ACK_TIMEOUT`.
- `tx_ready` is never asserted while `online` = 0.

## Structure
- Package `mpu_pkg` holds:
  - State enum.
  - `MPU_CMD_RESET` = 8'hFF, `MPU_CMD_UART` = 8'h3F, `MPU_ACK` = 8'hFE.
  - Status bit indices `MPU_ST_DSR` = 7, `MPU_ST_DRR` = 6.
  - Address constants.
- Single module; no sub-modules. The counters (gap, timeout, retry flag) live inline.

## Test plan
- Reset, then a slave model acking both commands → writes 0xFF then 0x3F at address 1, reads 0xFE twice, `online` = 1, `error` = 0.
- Slave in UART mode (no ack to the first 0xFF) → timeout after 65535 cycles, 0xFF resent, acked, then 0x3F → `online` = 1.
- Slave never acks → `error` = 1 after the second 0xFF timeout. `reinit` pulse → init restarts, `error` cleared.
- Online, `tx_valid` with 0x90,0x3C,0x7F while the slave holds bit6 = 1 for 20 cycles → no write until bit6 clears, then the three bytes are written to address 0 in order, each with a single `tx_ready`.
- Online, slave presents 0xFE then 0x45 while `tx_valid` is pending → both bytes appear on `rx_data` with `rx_valid` pulses before any TX write.
- Stray byte 0x80 during the ack wait → discarded (no `rx_valid`), 0xFE still accepted, init completes.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU-401 host-side initiator: sequencer states,
// command/ack byte values, status bit positions and register addresses.
package mpu_pkg;

    // Sequencer states. ST_C_* issue a command, ST_A_* wait for its ack,
    // the remainder form the UART-mode shuttle loop.
    typedef enum logic [3:0] {
        ST_C_POLL = 4'd0,   // idle cycle before polling for command space
        ST_C_STAT = 4'd1,   // status read strobe (address 1)
        ST_C_EVAL = 4'd2,   // sample status, wait for output-not-full
        ST_C_WR   = 4'd3,   // command write strobe (address 1)
        ST_A_HOLD = 4'd4,   // bus turnaround after the command write
        ST_A_STAT = 4'd5,   // status read strobe while waiting for ack
        ST_A_EVAL = 4'd6,   // sample status, wait for data-available
        ST_A_RD   = 4'd7,   // data read strobe (address 0)
        ST_A_SAMP = 4'd8,   // sample the candidate ack byte
        ST_STATUS = 4'd9,   // online: status read strobe
        ST_EVAL   = 4'd10,  // online: choose RX, TX or gap
        ST_RX_RD  = 4'd11,  // online: data read strobe
        ST_RX_CAP = 4'd12,  // online: capture the received byte
        ST_TX_WR  = 4'd13,  // online: data write strobe
        ST_GAP    = 4'd14,  // online: idle between polls
        ST_ERROR  = 4'd15   // init failed, bus quiet until reinit
    } mpu_state_e;

    localparam logic [7:0] MPU_CMD_RESET = 8'hFF;
    localparam logic [7:0] MPU_CMD_UART  = 8'h3F;
    localparam logic [7:0] MPU_ACK       = 8'hFE;

    // Status byte: DSR low means a byte is waiting, DRR high means output full.
    localparam int MPU_ST_DSR = 7;
    localparam int MPU_ST_DRR = 6;

    localparam logic MPU_ADDR_DATA = 1'b0;
    localparam logic MPU_ADDR_CMD  = 1'b1;

endpackage

// File: rtl/mpu_host.sv
// MPU-401 host-side initiator. After reset it resets the port, switches it to
// UART mode and then moves MIDI bytes between the port and the tx/rx streams.
// All bus strobes and stream handshakes are registered together with the state
// they belong to, so a strobe is high exactly while the FSM sits in its state.
module mpu_host
    import mpu_pkg::*;
#(
    parameter int POLL_GAP    = 3,
    parameter int ACK_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       reset,
    output logic       mpu_cs,
    output logic       mpu_address,
    output logic       mpu_read,
    output logic       mpu_write,
    output logic [7:0] mpu_writedata,
    input  logic [7:0] mpu_readdata,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       reinit,
    output logic       online,
    output logic       error
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [TW-1:0] TOUT_MAX = TW'(ACK_TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

    mpu_state_e  state_r;
    logic [7:0]  cmd_r;
    logic [TW-1:0] tout_r;
    logic [GW-1:0] gap_r;
    logic        retry_r;
    logic        cs_r;
    logic        addr_r;
    logic        rd_r;
    logic        wr_r;
    logic [7:0]  wdata_r;
    logic [7:0]  rx_data_r;
    logic        rx_valid_r;
    logic        tx_ready_r;
    logic        online_r;
    logic        error_r;

    logic        rx_avail_s;
    logic        out_full_s;
    logic        timeout_s;
    logic        to_fatal_s;
    logic        ack_wait_s;

    assign rx_avail_s = ~mpu_readdata[MPU_ST_DSR];
    assign out_full_s = mpu_readdata[MPU_ST_DRR];
    assign timeout_s  = (tout_r == TOUT_MAX);
    // The reset command gets one resend: a port already in UART mode ignores the first one.
    assign to_fatal_s = (cmd_r != MPU_CMD_RESET) || retry_r;
    assign ack_wait_s = (state_r == ST_A_HOLD) || (state_r == ST_A_STAT) ||
                        (state_r == ST_A_EVAL) || (state_r == ST_A_RD) ||
                        (state_r == ST_A_SAMP);

    assign mpu_cs        = cs_r;
    assign mpu_address   = addr_r;
    assign mpu_read      = rd_r;
    assign mpu_write     = wr_r;
    assign mpu_writedata = wdata_r;
    assign rx_data       = rx_data_r;
    assign rx_valid      = rx_valid_r;
    assign tx_ready      = tx_ready_r;
    assign online        = online_r;
    assign error         = error_r;

    // Ack timeout counter: cleared by the command write, saturates while waiting for the ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tout_r <= '0;
        end else if (state_r == ST_C_WR) begin
            tout_r <= '0;
        end else if (ack_wait_s && !timeout_s) begin
            tout_r <= tout_r + TW'(1);
        end else begin
            tout_r <= tout_r;
        end
    end

    // Protocol sequencer with registered bus strobes and stream handshakes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_C_POLL;
            cmd_r      <= MPU_CMD_RESET;
            gap_r      <= '0;
            retry_r    <= 1'b0;
            cs_r       <= 1'b0;
            addr_r     <= MPU_ADDR_DATA;
            rd_r       <= 1'b0;
            wr_r       <= 1'b0;
            wdata_r    <= 8'h00;
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
            tx_ready_r <= 1'b0;
            online_r   <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            cs_r       <= 1'b0;
            addr_r     <= MPU_ADDR_DATA;
            rd_r       <= 1'b0;
            wr_r       <= 1'b0;
            rx_valid_r <= 1'b0;
            tx_ready_r <= 1'b0;
            case (state_r)
                ST_C_POLL: begin
                    state_r <= ST_C_STAT;
                    cs_r    <= 1'b1;
                    rd_r    <= 1'b1;
                    addr_r  <= MPU_ADDR_CMD;
                end
                ST_C_STAT: begin
                    state_r <= ST_C_EVAL;
                end
                ST_C_EVAL: begin
                    cs_r   <= 1'b1;
                    addr_r <= MPU_ADDR_CMD;
                    if (out_full_s) begin
                        state_r <= ST_C_STAT;
                        rd_r    <= 1'b1;
                    end else begin
                        state_r <= ST_C_WR;
                        wr_r    <= 1'b1;
                        wdata_r <= cmd_r;
                    end
                end
                ST_C_WR: begin
                    state_r <= ST_A_HOLD;
                end
                ST_A_HOLD: begin
                    if (timeout_s && to_fatal_s) begin
                        state_r <= ST_ERROR;
                        error_r <= 1'b1;
                    end else if (timeout_s) begin
                        state_r <= ST_C_POLL;
                        retry_r <= 1'b1;
                    end else begin
                        state_r <= ST_A_STAT;
                        cs_r    <= 1'b1;
                        rd_r    <= 1'b1;
                        addr_r  <= MPU_ADDR_CMD;
                    end
                end
                ST_A_STAT: begin
                    state_r <= ST_A_EVAL;
                end
                ST_A_EVAL: begin
                    if (timeout_s && to_fatal_s) begin
                        state_r <= ST_ERROR;
                        error_r <= 1'b1;
                    end else if (timeout_s) begin
                        state_r <= ST_C_POLL;
                        retry_r <= 1'b1;
                    end else if (rx_avail_s) begin
                        state_r <= ST_A_RD;
                        cs_r    <= 1'b1;
                        rd_r    <= 1'b1;
                        addr_r  <= MPU_ADDR_DATA;
                    end else begin
                        state_r <= ST_A_STAT;
                        cs_r    <= 1'b1;
                        rd_r    <= 1'b1;
                        addr_r  <= MPU_ADDR_CMD;
                    end
                end
                ST_A_RD: begin
                    state_r <= ST_A_SAMP;
                end
                ST_A_SAMP: begin
                    if (mpu_readdata == MPU_ACK) begin
                        if (cmd_r == MPU_CMD_RESET) begin
                            state_r <= ST_C_POLL;
                            cmd_r   <= MPU_CMD_UART;
                        end else begin
                            state_r  <= ST_STATUS;
                            online_r <= 1'b1;
                            cs_r     <= 1'b1;
                            rd_r     <= 1'b1;
                            addr_r   <= MPU_ADDR_CMD;
                        end
                    end else if (timeout_s && to_fatal_s) begin
                        state_r <= ST_ERROR;
                        error_r <= 1'b1;
                    end else if (timeout_s) begin
                        state_r <= ST_C_POLL;
                        retry_r <= 1'b1;
                    end else begin
                        // Stray byte: dropped, keep waiting on the same timeout budget.
                        state_r <= ST_A_STAT;
                        cs_r    <= 1'b1;
                        rd_r    <= 1'b1;
                        addr_r  <= MPU_ADDR_CMD;
                    end
                end
                ST_STATUS: begin
                    state_r <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (reinit) begin
                        state_r  <= ST_C_POLL;
                        cmd_r    <= MPU_CMD_RESET;
                        retry_r  <= 1'b0;
                        online_r <= 1'b0;
                        error_r  <= 1'b0;
                    end else if (rx_avail_s) begin
                        state_r <= ST_RX_RD;
                        cs_r    <= 1'b1;
                        rd_r    <= 1'b1;
                        addr_r  <= MPU_ADDR_DATA;
                    end else if (tx_valid && !out_full_s) begin
                        state_r    <= ST_TX_WR;
                        cs_r       <= 1'b1;
                        wr_r       <= 1'b1;
                        addr_r     <= MPU_ADDR_DATA;
                        wdata_r    <= tx_data;
                        tx_ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_GAP;
                        gap_r   <= '0;
                    end
                end
                ST_RX_RD: begin
                    state_r <= ST_RX_CAP;
                end
                ST_RX_CAP: begin
                    state_r    <= ST_STATUS;
                    rx_data_r  <= mpu_readdata;
                    rx_valid_r <= 1'b1;
                    cs_r       <= 1'b1;
                    rd_r       <= 1'b1;
                    addr_r     <= MPU_ADDR_CMD;
                end
                ST_TX_WR: begin
                    state_r <= ST_STATUS;
                    cs_r    <= 1'b1;
                    rd_r    <= 1'b1;
                    addr_r  <= MPU_ADDR_CMD;
                end
                ST_GAP: begin
                    if (reinit) begin
                        state_r  <= ST_C_POLL;
                        cmd_r    <= MPU_CMD_RESET;
                        retry_r  <= 1'b0;
                        online_r <= 1'b0;
                        error_r  <= 1'b0;
                    end else if (gap_r == GAP_LAST) begin
                        state_r <= ST_STATUS;
                        cs_r    <= 1'b1;
                        rd_r    <= 1'b1;
                        addr_r  <= MPU_ADDR_CMD;
                    end else begin
                        gap_r <= gap_r + GW'(1);
                    end
                end
                ST_ERROR: begin
                    if (reinit) begin
                        state_r  <= ST_C_POLL;
                        cmd_r    <= MPU_CMD_RESET;
                        retry_r  <= 1'b0;
                        online_r <= 1'b0;
                        error_r  <= 1'b0;
                    end else begin
                        state_r <= ST_ERROR;
                    end
                end
                default: begin
                    state_r <= ST_C_POLL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_host.sv
// Self-checking bench for mpu_host: a behavioural MPU-401 slave, a bus/handshake
// monitor, a table of online traffic vectors and hand-written init sequences.
module tb_mpu_host;

    localparam int PG = 3;
    localparam int TO = 300;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       mpu_cs, mpu_address, mpu_read, mpu_write;
    logic [7:0] mpu_writedata;
    logic [7:0] mpu_readdata = 8'h00;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       reinit = 1'b0;
    logic       online;
    logic       error;

    mpu_host #(.POLL_GAP(PG), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .mpu_cs(mpu_cs), .mpu_address(mpu_address), .mpu_read(mpu_read),
        .mpu_write(mpu_write), .mpu_writedata(mpu_writedata),
        .mpu_readdata(mpu_readdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .reinit(reinit), .online(online), .error(error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Slave model controls: 0 ack all, 1 ignore first reset, 2 never ack, 3 stray 0x80 before acks
    int         mode = 0;
    logic       force_full = 1'b0;
    logic       hide_rx = 1'b0;
    logic       ff_seen = 1'b0;
    logic [7:0] rxq[$];

    // Behavioural MPU-401 slave with registered read data.
    always @(posedge clk) begin
        if (!reset) begin
            ff_seen <= 1'b0;
        end else begin
            if (mpu_cs && mpu_read) begin
                if (mpu_address)
                    mpu_readdata <= {((rxq.size() > 0 && !hide_rx) ? 1'b0 : 1'b1), force_full, 6'b000000};
                else if (rxq.size() > 0)
                    mpu_readdata <= rxq.pop_front();
                else
                    mpu_readdata <= 8'h00;
            end
            if (mpu_cs && mpu_write && mpu_address) begin
                if (mpu_writedata == 8'hFF) begin
                    if (mode == 2 || (mode == 1 && !ff_seen)) begin
                        ff_seen <= 1'b1;
                    end else begin
                        if (mode == 3) rxq.push_back(8'h80);
                        rxq.push_back(8'hFE);
                    end
                end else if (mpu_writedata == 8'h3F && mode != 2) begin
                    if (mode == 3) rxq.push_back(8'h80);
                    rxq.push_back(8'hFE);
                end
            end
        end
    end

    int         cyc = 0;
    int         viol = 0;
    int         lat_err = 0;
    int         strobes = 0;
    int         rdy_cnt = 0;
    int         last_rd0 = -100;
    int         last_rd1 = -100;
    logic       prev_st = 1'b0;
    logic       prev_txwr = 1'b0;
    logic [7:0] rx_log[$];
    logic [7:0] wr_log[$];
    logic [7:0] cmd_log[$];
    int         cmd_cyc[$];
    int         wr_cyc[$];
    logic [8:0] ev_log[$];

    // Bus monitor: records transfers and counts protocol and latency violations.
    always @(negedge clk) begin
        int v;
        v = 0;
        cyc <= cyc + 1;
        if (!reset) begin
            prev_st   <= 1'b0;
            prev_txwr <= 1'b0;
        end else begin
            if (mpu_read && mpu_write) v = v + 1;
            if ((mpu_read || mpu_write) && !mpu_cs) v = v + 1;
            if (prev_st && (mpu_read || mpu_write) && !(prev_txwr && mpu_read && mpu_address)) v = v + 1;
            if (tx_ready && !(online && mpu_write && !mpu_address && tx_valid)) v = v + 1;
            viol <= viol + v;
            if (mpu_read || mpu_write) strobes <= strobes + 1;
            if (tx_ready) rdy_cnt <= rdy_cnt + 1;
            if (mpu_read && !mpu_address) last_rd0 <= cyc;
            if (mpu_read && mpu_address) last_rd1 <= cyc;
            if (mpu_write && mpu_address) begin
                cmd_log.push_back(mpu_writedata);
                cmd_cyc.push_back(cyc);
            end
            if (mpu_write && !mpu_address) begin
                wr_log.push_back(mpu_writedata);
                wr_cyc.push_back(cyc);
                ev_log.push_back({1'b0, mpu_writedata});
                if (cyc - last_rd1 != 2) lat_err <= lat_err + 1;
            end
            if (rx_valid) begin
                rx_log.push_back(rx_data);
                ev_log.push_back({1'b1, rx_data});
                if (cyc - last_rd0 != 2) lat_err <= lat_err + 1;
            end
            prev_st   <= mpu_read || mpu_write;
            prev_txwr <= mpu_write && !mpu_address;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int m);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_online", {31'd0, online}, 32'd0);
        mode = m;
        force_full = 1'b0;
        hide_rx = 1'b0;
        tx_valid = 1'b0;
        reinit = 1'b0;
        rxq.delete();
        cmd_log.delete();
        cmd_cyc.delete();
        rx_log.delete();
        wr_log.delete();
        wr_cyc.delete();
        ev_log.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_online(input string name, input int budget);
        int n;
        n = 0;
        while (!online && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, online}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, output int lat);
        int n;
        n = 0;
        tx_data = b;
        tx_valid = 1'b1;
        @(negedge clk);
        while (!tx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("tx_accept", {31'd0, tx_ready}, 32'd1);
        lat = n;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    typedef struct {
        logic       is_rx;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n;
        int lat;
        int r0;
        int clr;
        int s0;
        int gap;

        vecs[0] = '{1'b0, 8'h90, 8'h90};
        vecs[1] = '{1'b0, 8'h3C, 8'h3C};
        vecs[2] = '{1'b1, 8'h45, 8'h45};
        vecs[3] = '{1'b1, 8'hFE, 8'hFE};
        vecs[4] = '{1'b0, 8'h7F, 8'h7F};
        vecs[5] = '{1'b1, 8'h00, 8'h00};
        vecs[6] = '{1'b0, 8'hFF, 8'hFF};
        vecs[7] = '{1'b1, 8'h80, 8'h80};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_strobes", {29'd0, mpu_cs, mpu_read, mpu_write}, 32'd0);
        check("rst_wdata", {24'd0, mpu_writedata}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_flags", {28'd0, rx_valid, tx_ready, online, error}, 32'd0);
        reset = 1'b1;

        // Normal init: 0xFF then 0x3F, both acked
        wait_online("t1_online", 2000);
        check("t1_error", {31'd0, error}, 32'd0);
        check("t1_cmd_n", cmd_log.size(), 32'd2);
        if (cmd_log.size() == 2) begin
            check("t1_cmd0", {24'd0, cmd_log[0]}, 32'hFF);
            check("t1_cmd1", {24'd0, cmd_log[1]}, 32'h3F);
        end
        check("t1_no_rx", rx_log.size(), 32'd0);

        // Online traffic table
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_rx) begin
                rx_log.delete();
                rxq.push_back(vecs[i].din);
                n = 0;
                while (rx_log.size() == 0 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check("rx_count", rx_log.size(), 32'd1);
                if (rx_log.size() > 0) check("rx_byte", {24'd0, rx_log[0]}, {24'd0, vecs[i].exp});
                repeat (4) @(negedge clk);
                check("rx_data_hold", {24'd0, rx_data}, {24'd0, vecs[i].exp});
                check("rx_valid_pulse", {31'd0, rx_valid}, 32'd0);
            end else begin
                wr_log.delete();
                send_byte(vecs[i].din, lat);
                repeat (2) @(negedge clk);
                check("tx_count", wr_log.size(), 32'd1);
                if (wr_log.size() > 0) check("tx_byte", {24'd0, wr_log[0]}, {24'd0, vecs[i].exp});
                check("tx_latency", {31'd0, (lat <= PG + 3)}, 32'd1);
            end
            repeat (3) @(negedge clk);
        end

        // Output full for 20 cycles while three bytes are pending
        force_full = 1'b1;
        r0 = rdy_cnt;
        wr_log.delete();
        wr_cyc.delete();
        clr = 0;
        fork
            begin
                send_byte(8'h90, lat);
                send_byte(8'h3C, lat);
                send_byte(8'h7F, lat);
            end
            begin
                repeat (20) @(negedge clk);
                clr = cyc;
                force_full = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        check("full_wr_n", wr_log.size(), 32'd3);
        if (wr_log.size() == 3) begin
            check("full_wr0", {24'd0, wr_log[0]}, 32'h90);
            check("full_wr1", {24'd0, wr_log[1]}, 32'h3C);
            check("full_wr2", {24'd0, wr_log[2]}, 32'h7F);
            check("full_wait", {31'd0, (wr_cyc[0] > clr)}, 32'd1);
        end
        check("full_ready_n", rdy_cnt - r0, 32'd3);

        // RX has priority over a pending TX byte
        hide_rx = 1'b1;
        force_full = 1'b1;
        ev_log.delete();
        rxq.push_back(8'hFE);
        rxq.push_back(8'h45);
        fork
            send_byte(8'h55, lat);
            begin
                repeat (6) @(negedge clk);
                hide_rx = 1'b0;
                force_full = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("prio_ev_n", ev_log.size(), 32'd3);
        if (ev_log.size() == 3) begin
            check("prio_ev0", {23'd0, ev_log[0]}, 32'h1FE);
            check("prio_ev1", {23'd0, ev_log[1]}, 32'h145);
            check("prio_ev2", {23'd0, ev_log[2]}, 32'h055);
        end

        // Port already in UART mode: first reset unacked, resent after the timeout
        do_reset(1);
        wait_online("uart_online", 4 * TO);
        check("uart_cmd_n", cmd_log.size(), 32'd3);
        if (cmd_log.size() == 3) begin
            check("uart_cmd0", {24'd0, cmd_log[0]}, 32'hFF);
            check("uart_cmd1", {24'd0, cmd_log[1]}, 32'hFF);
            check("uart_cmd2", {24'd0, cmd_log[2]}, 32'h3F);
            gap = cmd_cyc[1] - cmd_cyc[0];
            check("uart_retry_gap", {31'd0, (gap >= TO && gap <= TO + 30)}, 32'd1);
        end
        check("uart_error", {31'd0, error}, 32'd0);

        // Stray byte during the ack wait is dropped
        do_reset(3);
        wait_online("stray_online", 2000);
        check("stray_no_rx", rx_log.size(), 32'd0);
        check("stray_cmd_n", cmd_log.size(), 32'd2);

        // Never acked: error after the second reset timeout, then reinit recovers
        do_reset(2);
        n = 0;
        while (!error && n < 4 * TO) begin
            @(negedge clk);
            n++;
        end
        check("nack_error", {31'd0, error}, 32'd1);
        check("nack_online", {31'd0, online}, 32'd0);
        check("nack_cmd_n", cmd_log.size(), 32'd2);
        s0 = strobes;
        repeat (20) @(negedge clk);
        check("nack_bus_quiet", strobes - s0, 32'd0);
        mode = 0;
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        @(negedge clk);
        check("reinit_error_clr", {31'd0, error}, 32'd0);
        wait_online("reinit_online", 2000);
        check("reinit_cmd_n", cmd_log.size(), 32'd4);
        if (cmd_log.size() == 4) begin
            check("reinit_cmd2", {24'd0, cmd_log[2]}, 32'hFF);
            check("reinit_cmd3", {24'd0, cmd_log[3]}, 32'h3F);
        end

        repeat (10) @(negedge clk);
        check("protocol_viol", viol, 32'd0);
        check("latency_err", lat_err, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
